fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 52, number of valid instruction words (addresses 0..MEM_DEPTH-1).
REQ-002 SHALL have parameter HALT_OPCODE, default 6'b111111, value of instr[31:26] that halts fetch.
REQ-003 reloj  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hold PC and IF/ID contents.
REQ-006 flush  input  1  invalidate the IF/ID entry on the next edge.
REQ-007 jump  input  1  redirect PC to jump_target.
REQ-008 jump_target  input  6  absolute word address.
REQ-009 branch_taken  input  1  redirect PC to branch target.
REQ-010 branch_offset  input  16  signed word offset, relative to ifid_pc_plus1.
REQ-011 imem_addr  output  6  word address to instruction memory (combinational read, data same cycle).
REQ-012 imem_data  input  32  instruction word from memory.
REQ-013 ifid_instr  output  32  registered instruction.
REQ-014 ifid_pc_plus1  output  6  registered address of the next sequential instruction.
REQ-015 ifid_valid  output  1  ifid_instr holds a real instruction.
REQ-016 halted  output  1  fetch stopped on HALT_OPCODE.

Function
REQ-017 imem_addr SHALL equal the PC register directly (no added delay); ifid_* SHALL capture imem_data and the next-sequential address on the following edge (latency 1).
REQ-018 Sequential next PC SHALL be pc+1, wrapping to 0 when pc = MEM_DEPTH-1.
REQ-019 Branch target SHALL be (ifid_pc_plus1 + branch_offset[5:0]) mod 64; any target >= MEM_DEPTH SHALL be replaced by 0; the same >= MEM_DEPTH rule SHALL apply to jump_target.
REQ-020 Priority per edge SHALL be: reset > jump > branch_taken > stall > sequential.
REQ-021 Jump or branch_taken SHALL load the target into PC, clear ifid_valid, and override stall in the same cycle.
REQ-022 flush without redirect SHALL clear ifid_valid, load ifid_instr with 0, and advance PC sequentially unless stall is high.
REQ-023 stall (no redirect) SHALL hold PC, ifid_instr, ifid_pc_plus1, and ifid_valid unchanged; flush with stall SHALL still clear ifid_valid.
REQ-024 FSM states SHALL be BOOT, RUN, and HALT.
REQ-025 BOOT is entered on reset, lasts one cycle with ifid_valid=0, then goes to RUN.
REQ-026 RUN SHALL go to HALT on the edge where a fetched word with instr[31:26]=HALT_OPCODE is captured (not stalled, not redirected); that word SHALL still be presented with ifid_valid=1.
REQ-027 HALT SHALL freeze PC, drive ifid_valid=0 from the next cycle, hold halted=1, and be left only by reset; jump or branch in HALT SHALL be ignored.

Reset
REQ-028 On reset, PC SHALL be 0, ifid_instr 0, ifid_pc_plus1 0, ifid_valid 0, halted 0, and the state BOOT.
REQ-029 Reset asserted mid-operation, including with stall, redirect, or HALT active, SHALL take effect on that edge with the values above.

Configuration
REQ-030 Macro FETCH_PERF_CNT_EN defined SHALL add output fetch_count, 16 bits: counts edges that capture a valid instruction, saturates at 16'hFFFF, and clears on reset.
REQ-031 Macro FETCH_PERF_CNT_EN undefined SHALL omit the fetch_count port and its counter entirely; all other behaviour SHALL be identical.

Verification
REQ-032 Reset, memory holding 0..3 -> imem_addr 0,0,1,2; ifid_valid 0 in BOOT, then 1 with ifid_instr = words 0,1,2 one cycle behind.
REQ-033 Free-run to address 51 -> next imem_addr 0; ifid_pc_plus1 = 0 when word 51 is captured.
REQ-034 stall for 3 cycles at PC=5 -> imem_addr stays 5; ifid_* unchanged; flush during the stall -> ifid_valid 0.
REQ-035 branch_taken with ifid_pc_plus1=10 and offset -4 -> PC=6, ifid_valid 0 next cycle; jump=1 with branch_taken=1, jump_target=20 -> PC=20; jump_target=60 -> PC=0.
REQ-036 Word with instr[31:26]=6'b111111 at address 7 -> it is captured valid, halted=1, PC frozen, and later jump ignored; reset -> PC=0, halted=0.
REQ-037 With FETCH_PERF_CNT_EN, 10 valid fetches with 2 flushes -> fetch_count=8 (flushed or invalid edges are not counted).

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID latch and BOOT/RUN/HALT control.
// Optional FETCH_PERF_CNT_EN adds a saturating count of valid captures.
module fetch_unit #(
    parameter int          MEM_DEPTH   = 52,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic        reloj,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        jump,
    input  logic [5:0]  jump_target,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    output logic [5:0]  imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] ifid_instr,
    output logic [5:0]  ifid_pc_plus1,
    output logic        ifid_valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0] fetch_count,
`endif
    output logic        halted
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t      state, state_n;
    logic [5:0]  pc, pc_n, pc_seq, br_tgt, pcp1_n;
    logic [31:0] instr_n;
    logic        valid_n, cap;

    // Targets outside the populated memory fall back to address 0.
    function automatic logic [5:0] clamp(input logic [5:0] t);
        return ({26'd0, t} >= MEM_DEPTH) ? 6'd0 : t;
    endfunction

    assign pc_seq    = (pc == 6'(MEM_DEPTH - 1)) ? 6'd0 : pc + 6'd1;
    assign br_tgt    = clamp(ifid_pc_plus1 + branch_offset[5:0]);
    assign imem_addr = pc;
    assign halted    = (state == HALT);

    always_comb begin
        state_n = state;
        pc_n    = pc;
        instr_n = ifid_instr;
        pcp1_n  = ifid_pc_plus1;
        valid_n = ifid_valid;
        cap     = 1'b0;
        case (state)
            BOOT: begin
                state_n = RUN;
                valid_n = 1'b0;
            end
            RUN: begin
                if (jump) begin
                    pc_n    = clamp(jump_target);
                    valid_n = 1'b0;
                end else if (branch_taken) begin
                    pc_n    = br_tgt;
                    valid_n = 1'b0;
                end else if (stall) begin
                    if (flush) valid_n = 1'b0;
                end else if (flush) begin
                    pc_n    = pc_seq;
                    pcp1_n  = pc_seq;
                    instr_n = 32'd0;
                    valid_n = 1'b0;
                end else begin
                    // Normal capture; a halt word is still delivered valid.
                    cap     = 1'b1;
                    pc_n    = pc_seq;
                    pcp1_n  = pc_seq;
                    instr_n = imem_data;
                    valid_n = 1'b1;
                    if (imem_data[31:26] == HALT_OPCODE) state_n = HALT;
                end
            end
            HALT: valid_n = 1'b0;
            default: state_n = BOOT;
        endcase
    end

    always_ff @(posedge reloj) begin
        if (reset) begin
            state         <= BOOT;
            pc            <= 6'd0;
            ifid_instr    <= 32'd0;
            ifid_pc_plus1 <= 6'd0;
            ifid_valid    <= 1'b0;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            ifid_instr    <= instr_n;
            ifid_pc_plus1 <= pcp1_n;
            ifid_valid    <= valid_n;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge reloj) begin
        if (reset)                            fetch_count <= 16'd0;
        else if (cap && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural combinational instruction memory.
module tb_fetch_unit;
    logic        reloj = 1'b0;
    logic        reset, stall, flush, jump, branch_taken;
    logic [5:0]  jump_target;
    logic [15:0] branch_offset;
    logic [5:0]  imem_addr;
    logic [31:0] imem_data, ifid_instr;
    logic [5:0]  ifid_pc_plus1;
    logic        ifid_valid, halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_count;
`endif
    logic [31:0] mem [0:63];
    int total = 0, bad = 0;

    always #5 reloj = ~reloj;
    assign imem_data = mem[imem_addr];

    fetch_unit dut (
        .reloj(reloj), .reset(reset), .stall(stall), .flush(flush),
        .jump(jump), .jump_target(jump_target), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .imem_addr(imem_addr), .imem_data(imem_data),
        .ifid_instr(ifid_instr), .ifid_pc_plus1(ifid_pc_plus1), .ifid_valid(ifid_valid),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count(fetch_count),
`endif
        .halted(halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge reloj);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic run_to_addr(input logic [5:0] a);
        for (int i = 0; i < 128 && imem_addr != a; i++) step();
        check("reach_addr", {26'd0, imem_addr}, {26'd0, a});
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = i;
        reset = 0; stall = 0; flush = 0; jump = 0; branch_taken = 0;
        jump_target = 0; branch_offset = 0;
        #2;

        // reset values and BOOT cycle
        do_reset();
        check("rst_addr", {26'd0, imem_addr}, 0);
        check("rst_valid", {31'd0, ifid_valid}, 0);
        check("rst_instr", ifid_instr, 0);
        check("rst_pcp1", {26'd0, ifid_pc_plus1}, 0);
        check("rst_halted", {31'd0, halted}, 0);
        step();
        check("boot_addr", {26'd0, imem_addr}, 0);
        check("boot_valid", {31'd0, ifid_valid}, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("seq_addr", {26'd0, imem_addr}, k + 1);
            check("seq_instr", ifid_instr, k);
            check("seq_valid", {31'd0, ifid_valid}, 1);
            check("seq_pcp1", {26'd0, ifid_pc_plus1}, k + 1);
        end

        // wrap at MEM_DEPTH-1
        run_to_addr(6'd51);
        step();
        check("wrap_addr", {26'd0, imem_addr}, 0);
        check("wrap_instr", ifid_instr, 51);
        check("wrap_pcp1", {26'd0, ifid_pc_plus1}, 0);

        // stall holds, flush under stall clears valid
        run_to_addr(6'd5);
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_addr", {26'd0, imem_addr}, 5);
            check("stall_instr", ifid_instr, 4);
            check("stall_pcp1", {26'd0, ifid_pc_plus1}, 5);
            check("stall_valid", {31'd0, ifid_valid}, 1);
        end
        flush = 1;
        step();
        check("stflush_valid", {31'd0, ifid_valid}, 0);
        check("stflush_addr", {26'd0, imem_addr}, 5);
        stall = 0; flush = 0;
        step();
        check("resume_instr", ifid_instr, 5);
        check("resume_addr", {26'd0, imem_addr}, 6);

        // branch -4 from pcp1=10
        run_to_addr(6'd10);
        check("br_pcp1", {26'd0, ifid_pc_plus1}, 10);
        branch_taken = 1; branch_offset = 16'hFFFC;
        step();
        check("br_addr", {26'd0, imem_addr}, 6);
        check("br_valid", {31'd0, ifid_valid}, 0);
        branch_taken = 0;
        step();
        check("br_instr", ifid_instr, 6);
        check("br_valid2", {31'd0, ifid_valid}, 1);

        // jump beats branch; out-of-range jump target -> 0
        jump = 1; jump_target = 20; branch_taken = 1;
        step();
        check("jmp_addr", {26'd0, imem_addr}, 20);
        check("jmp_valid", {31'd0, ifid_valid}, 0);
        branch_taken = 0; jump_target = 60;
        step();
        check("jmp60_addr", {26'd0, imem_addr}, 0);
        jump = 0;
        step();
        check("jmp_instr", ifid_instr, 0);
        check("jmp_addr2", {26'd0, imem_addr}, 1);

        // plain flush advances PC and zeroes instr
        flush = 1;
        step();
        check("fl_addr", {26'd0, imem_addr}, 2);
        check("fl_valid", {31'd0, ifid_valid}, 0);
        check("fl_instr", ifid_instr, 0);
        flush = 0;

        // halt word at address 7
        mem[7] = 32'hFC000007;
        do_reset();
        step();
        run_to_addr(6'd7);
        step();
        check("hlt_instr", ifid_instr, 32'hFC000007);
        check("hlt_valid", {31'd0, ifid_valid}, 1);
        check("hlt_halted", {31'd0, halted}, 1);
        step();
        check("hlt_valid2", {31'd0, ifid_valid}, 0);
        check("hlt_addr", {26'd0, imem_addr}, 8);
        jump = 1; jump_target = 3;
        step();
        check("hlt_jmp_addr", {26'd0, imem_addr}, 8);
        check("hlt_jmp_halted", {31'd0, halted}, 1);
        do_reset();
        jump = 0;
        check("hlt_rst_addr", {26'd0, imem_addr}, 0);
        check("hlt_rst_halted", {31'd0, halted}, 0);
        mem[7] = 7;

`ifdef FETCH_PERF_CNT_EN
        do_reset();
        check("cnt_rst", {16'd0, fetch_count}, 0);
        step();
        for (int k = 0; k < 10; k++) begin
            flush = (k == 3 || k == 7);
            step();
        end
        flush = 0;
        check("cnt_val", {16'd0, fetch_count}, 8);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
